// File: rtl/garuda_result_buffer.sv
// garuda_result_buffer
// Small FIFO that buffers MAC results (data, destination register, hart ID,
// transaction ID) until the core accepts them. Results that arrive while the
// buffer is full and nothing drains are dropped. A sticky overflow flag and a
// saturating drop counter record these drops.
//
// Optional feature: define GARUDA_RESULT_BYPASS_EN to let a result go straight
// through to the core in the same cycle when the buffer is empty. Without the
// macro, every output comes from registered state only.

module garuda_result_buffer #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 4,
  parameter int HARTID_W = 2,
  parameter int ID_W     = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       valid_i,
  input  logic                       we_i,
  input  logic [XLEN-1:0]            result_i,
  input  logic [4:0]                 rd_addr_i,
  input  logic [HARTID_W-1:0]        hartid_i,
  input  logic [ID_W-1:0]            id_i,
  input  logic                       clear_i,
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic [XLEN-1:0]            res_data_o,
  output logic [4:0]                 res_rd_addr_o,
  output logic [HARTID_W-1:0]        res_hartid_o,
  output logic [ID_W-1:0]            res_id_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o,
  output logic [7:0]                 drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] OneC   = CW'(1);

  typedef struct packed {
    logic [XLEN-1:0]     data;
    logic [4:0]          rdAddr;
    logic [HARTID_W-1:0] hartid;
    logic [ID_W-1:0]     id;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    dropCnt_q, dropCnt_d;

  entry_t inEntry;
  entry_t headEntry;
  logic   isEmpty;
  logic   isFull;
  logic   headValid;
  logic   pushReq;
  logic   popFire;
  logic   queuePop;
  logic   store;
  logic   drop;

`ifdef GARUDA_RESULT_BYPASS_EN
  logic   bypassHit;
  logic   bypassThrough;
`endif

  // Pack the incoming result fields and pick up the current head entry
  always_comb begin
    inEntry.data   = result_i;
    inEntry.rdAddr = rd_addr_i;
    inEntry.hartid = hartid_i;
    inEntry.id     = id_i;
    headEntry      = mem_q[rdPtr_q];
  end

  // Decide push, pop, store and drop for this cycle
  always_comb begin
    isEmpty   = (count_q == '0);
    isFull    = (count_q == DepthC);
    headValid = !isEmpty;
    pushReq   = valid_i && we_i && !clear_i;
`ifdef GARUDA_RESULT_BYPASS_EN
    // When empty, an incoming result is shown to the core directly. If the
    // core takes it right away, it never needs to enter the storage.
    bypassHit     = isEmpty && valid_i && we_i;
    popFire       = (headValid || bypassHit) && res_ready_i && !clear_i;
    bypassThrough = isEmpty && popFire;
    queuePop      = popFire && !isEmpty;
    store         = pushReq && (!isFull || popFire) && !bypassThrough;
`else
    popFire       = headValid && res_ready_i && !clear_i;
    queuePop      = popFire;
    store         = pushReq && (!isFull || popFire);
`endif
    drop          = pushReq && isFull && !popFire;
  end

  // Next-state for pointers, occupancy and drop bookkeeping
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    dropCnt_d  = dropCnt_q;
    if (clear_i) begin
      wrPtr_d    = '0;
      rdPtr_d    = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      dropCnt_d  = '0;
    end else begin
      if (store) begin
        wrPtr_d = wrPtr_q + 1'b1;
      end
      if (queuePop) begin
        rdPtr_d = rdPtr_q + 1'b1;
      end
      unique case ({store, queuePop})
        2'b10:   count_d = count_q + OneC;
        2'b01:   count_d = count_q - OneC;
        default: count_d = count_q;
      endcase
      if (drop) begin
        overflow_d = 1'b1;
        if (dropCnt_q != 8'hFF) begin
          dropCnt_d = dropCnt_q + 8'd1;
        end
      end
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      dropCnt_q  <= '0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      dropCnt_q  <= dropCnt_d;
    end
  end

  // Entry storage; needs no reset because the output is masked when empty
  always_ff @(posedge clk_i) begin
    if (!rst_i && !clear_i && store) begin
      mem_q[wrPtr_q] <= inEntry;
    end
  end

  // Present the head entry to the core, zeros when nothing is valid
  always_comb begin
    res_valid_o   = headValid;
    res_data_o    = '0;
    res_rd_addr_o = '0;
    res_hartid_o  = '0;
    res_id_o      = '0;
    if (headValid) begin
      res_data_o    = headEntry.data;
      res_rd_addr_o = headEntry.rdAddr;
      res_hartid_o  = headEntry.hartid;
      res_id_o      = headEntry.id;
    end
`ifdef GARUDA_RESULT_BYPASS_EN
    if (bypassHit) begin
      res_valid_o   = 1'b1;
      res_data_o    = inEntry.data;
      res_rd_addr_o = inEntry.rdAddr;
      res_hartid_o  = inEntry.hartid;
      res_id_o      = inEntry.id;
    end
`endif
  end

  // Status outputs come straight from registers
  always_comb begin
    full_o     = (count_q == DepthC);
    count_o    = count_q;
    overflow_o = overflow_q;
    drop_cnt_o = dropCnt_q;
  end

endmodule

// File: tb/tb_garuda_result_buffer.sv
// Testbench for garuda_result_buffer: directed scenarios with fixed expected
// values, followed by a randomized run checked against a queue-based model.

module tb_garuda_result_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int HW    = 2;
  localparam int IW    = 3;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
    logic [HW-1:0]   hart;
    logic [IW-1:0]   id;
  } tbEntry_t;

  logic            clk_i = 1'b0;
  logic            rst_i, valid_i, we_i, clear_i, res_ready_i;
  logic [XLEN-1:0] result_i;
  logic [4:0]      rd_addr_i;
  logic [HW-1:0]   hartid_i;
  logic [IW-1:0]   id_i;
  logic            res_valid_o, full_o, overflow_o;
  logic [XLEN-1:0] res_data_o;
  logic [4:0]      res_rd_addr_o;
  logic [HW-1:0]   res_hartid_o;
  logic [IW-1:0]   res_id_o;
  logic [2:0]      count_o;
  logic [7:0]      drop_cnt_o;

  int compared   = 0;
  int mismatched = 0;

  tbEntry_t refQ[$];
  bit       refOvf;
  int       refDrop;

  garuda_result_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .HARTID_W(HW), .ID_W(IW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .we_i(we_i),
    .result_i(result_i), .rd_addr_i(rd_addr_i), .hartid_i(hartid_i), .id_i(id_i),
    .clear_i(clear_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .res_rd_addr_o(res_rd_addr_o),
    .res_hartid_o(res_hartid_o), .res_id_o(res_id_o), .full_o(full_o),
    .count_o(count_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: a plain queue with drop bookkeeping
  task automatic modelStep(input bit r, input bit v, input bit w, input bit c,
                           input bit rdy, input tbEntry_t e);
    bit doPop;
    bit doPush;
    if (r || c) begin
      refQ.delete();
      refOvf  = 1'b0;
      refDrop = 0;
    end else begin
      doPop  = (refQ.size() != 0) && rdy;
      doPush = v && w;
      if (doPush && refQ.size() == DEPTH && !doPop) begin
        refOvf = 1'b1;
        if (refDrop < 255) refDrop++;
      end else begin
        if (doPop) void'(refQ.pop_front());
        if (doPush) refQ.push_back(e);
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model, settle 1 time unit
  task automatic driveCycle(input bit r, input bit v, input bit w, input bit c,
                            input bit rdy, input logic [XLEN-1:0] d,
                            input logic [4:0] rd, input logic [HW-1:0] h,
                            input logic [IW-1:0] id);
    tbEntry_t e;
    rst_i = r; valid_i = v; we_i = w; clear_i = c; res_ready_i = rdy;
    result_i = d; rd_addr_i = rd; hartid_i = h; id_i = id;
    e.data = d; e.rd = rd; e.hart = h; e.id = id;
    @(posedge clk_i);
    modelStep(r, v, w, c, rdy, e);
    #1;
  endtask

  task automatic test_reset();
    driveCycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    driveCycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    compared++; if (count_o !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_count: got %0d expected 0", count_o); end
    compared++; if ({res_valid_o, full_o, overflow_o} !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_flags: got %b expected 000", {res_valid_o, full_o, overflow_o}); end
    compared++; if (drop_cnt_o !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_drop: got %0d expected 0", drop_cnt_o); end
    compared++; if ({res_data_o, res_rd_addr_o, res_hartid_o, res_id_o} !== '0) begin mismatched++; $display("[TB] FAIL reset_fields: got %h expected 0", {res_data_o, res_rd_addr_o, res_hartid_o, res_id_o}); end
    driveCycle(0, 1, 1, 0, 0, 32'd11, 5'd1, 2'd1, 3'd1);
    driveCycle(0, 1, 1, 0, 0, 32'd12, 5'd2, 2'd1, 3'd2);
    compared++; if (count_o !== 3'd2) begin mismatched++; $display("[TB] FAIL pre_reset_count: got %0d expected 2", count_o); end
    driveCycle(1, 1, 1, 1, 1, 32'd13, 5'd3, 2'd1, 3'd3);
    compared++; if ({count_o, res_valid_o} !== {3'd0, 1'b0}) begin mismatched++; $display("[TB] FAIL midstream_reset: got count %0d valid %b expected 0 0", count_o, res_valid_o); end
  endtask

  task automatic test_single();
    driveCycle(0, 0, 0, 1, 0, 0, 0, 0, 0);
    driveCycle(0, 1, 1, 0, 1, 32'd25, 5'd5, 2'd0, 3'd1);
    compared++; if ({res_valid_o, res_data_o, res_rd_addr_o, res_id_o} !== {1'b1, 32'd25, 5'd5, 3'd1}) begin mismatched++; $display("[TB] FAIL single_head: got v%b d%0d rd%0d id%0d expected v1 d25 rd5 id1", res_valid_o, res_data_o, res_rd_addr_o, res_id_o); end
    compared++; if (count_o !== 3'd1) begin mismatched++; $display("[TB] FAIL single_count: got %0d expected 1", count_o); end
    driveCycle(0, 0, 0, 0, 1, 0, 0, 0, 0);
    compared++; if ({count_o, res_valid_o} !== {3'd0, 1'b0}) begin mismatched++; $display("[TB] FAIL single_drain: got count %0d valid %b expected 0 0", count_o, res_valid_o); end
  endtask

  task automatic test_fill_drain();
    logic [XLEN-1:0] exp [4];
    exp = '{32'd10, 32'd20, 32'd30, 32'd40};
    driveCycle(0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) driveCycle(0, 1, 1, 0, 0, exp[i], 5'(i + 1), 2'(i), 3'(i));
    compared++; if ({full_o, count_o} !== {1'b1, 3'd4}) begin mismatched++; $display("[TB] FAIL fill_full: got full %b count %0d expected 1 4", full_o, count_o); end
    driveCycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    compared++; if (res_data_o !== 32'd10) begin mismatched++; $display("[TB] FAIL fill_hold: got %0d expected 10", res_data_o); end
    for (int i = 0; i < 4; i++) begin
      compared++; if ({res_valid_o, res_data_o, res_rd_addr_o} !== {1'b1, exp[i], 5'(i + 1)}) begin mismatched++; $display("[TB] FAIL drain_order[%0d]: got v%b d%0d rd%0d expected v1 d%0d rd%0d", i, res_valid_o, res_data_o, res_rd_addr_o, exp[i], i + 1); end
      driveCycle(0, 0, 0, 0, 1, 0, 0, 0, 0);
    end
    compared++; if ({count_o, res_valid_o, full_o} !== {3'd0, 1'b0, 1'b0}) begin mismatched++; $display("[TB] FAIL drain_empty: got count %0d valid %b full %b expected 0 0 0", count_o, res_valid_o, full_o); end
  endtask

  task automatic test_overflow();
    driveCycle(0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) driveCycle(0, 1, 1, 0, 0, XLEN'(i), 5'd7, 2'd0, 3'd0);
    driveCycle(0, 1, 1, 0, 0, -32'sd15, 5'd9, 2'd3, 3'd5);
    compared++; if ({count_o, overflow_o, drop_cnt_o} !== {3'd4, 1'b1, 8'd1}) begin mismatched++; $display("[TB] FAIL overflow_first: got count %0d ovf %b drop %0d expected 4 1 1", count_o, overflow_o, drop_cnt_o); end
    for (int i = 0; i < 300; i++) driveCycle(0, 1, 1, 0, 0, $urandom, 5'd9, 2'd3, 3'd5);
    compared++; if ({overflow_o, drop_cnt_o} !== {1'b1, 8'd255}) begin mismatched++; $display("[TB] FAIL overflow_saturate: got ovf %b drop %0d expected 1 255", overflow_o, drop_cnt_o); end
    for (int i = 1; i <= 4; i++) begin
      compared++; if (res_data_o !== XLEN'(i)) begin mismatched++; $display("[TB] FAIL overflow_drain[%0d]: got %h expected %h", i, res_data_o, XLEN'(i)); end
      driveCycle(0, 0, 0, 0, 1, 0, 0, 0, 0);
    end
    compared++; if ({res_valid_o, overflow_o} !== 2'b01) begin mismatched++; $display("[TB] FAIL overflow_sticky: got valid %b ovf %b expected 0 1", res_valid_o, overflow_o); end
    driveCycle(0, 0, 0, 1, 0, 0, 0, 0, 0);
    compared++; if ({overflow_o, drop_cnt_o} !== {1'b0, 8'd0}) begin mismatched++; $display("[TB] FAIL overflow_clear: got ovf %b drop %0d expected 0 0", overflow_o, drop_cnt_o); end
  endtask

  task automatic test_push_pop_full();
    logic [XLEN-1:0] exp [4];
    exp = '{32'd6, 32'd7, 32'd8, 32'd127};
    driveCycle(0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 5; i <= 8; i++) driveCycle(0, 1, 1, 0, 0, XLEN'(i), 5'd1, 2'd0, 3'd0);
    driveCycle(0, 1, 1, 0, 1, 32'd127, 5'd2, 2'd1, 3'd6);
    compared++; if ({count_o, full_o, overflow_o, drop_cnt_o} !== {3'd4, 1'b1, 1'b0, 8'd0}) begin mismatched++; $display("[TB] FAIL pushpop_full: got count %0d full %b ovf %b drop %0d expected 4 1 0 0", count_o, full_o, overflow_o, drop_cnt_o); end
    for (int i = 0; i < 4; i++) begin
      compared++; if (res_data_o !== exp[i]) begin mismatched++; $display("[TB] FAIL pushpop_order[%0d]: got %0d expected %0d", i, res_data_o, exp[i]); end
      driveCycle(0, 0, 0, 0, 1, 0, 0, 0, 0);
    end
  endtask

  task automatic test_clear();
    driveCycle(0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) driveCycle(0, 1, 1, 0, 0, XLEN'(50 + i), 5'd3, 2'd0, 3'd0);
    compared++; if (count_o !== 3'd3) begin mismatched++; $display("[TB] FAIL clear_pre: got %0d expected 3", count_o); end
    driveCycle(0, 1, 1, 1, 1, 32'd99, 5'd4, 2'd0, 3'd0);
    compared++; if ({count_o, res_valid_o, full_o, drop_cnt_o} !== {3'd0, 1'b0, 1'b0, 8'd0}) begin mismatched++; $display("[TB] FAIL clear_push: got count %0d valid %b full %b drop %0d expected 0 0 0 0", count_o, res_valid_o, full_o, drop_cnt_o); end
  endtask

  task automatic test_write_disable();
    driveCycle(0, 0, 0, 1, 0, 0, 0, 0, 0);
    driveCycle(0, 1, 1, 0, 0, 32'd9, 5'd1, 2'd0, 3'd0);
    driveCycle(0, 1, 0, 0, 0, 32'd77, 5'd2, 2'd0, 3'd0);
    compared++; if ({count_o, res_data_o, drop_cnt_o} !== {3'd1, 32'd9, 8'd0}) begin mismatched++; $display("[TB] FAIL we0_partial: got count %0d head %0d drop %0d expected 1 9 0", count_o, res_data_o, drop_cnt_o); end
    for (int i = 0; i < 3; i++) driveCycle(0, 1, 1, 0, 0, 32'd9, 5'd1, 2'd0, 3'd0);
    driveCycle(0, 1, 0, 0, 0, 32'd77, 5'd2, 2'd0, 3'd0);
    compared++; if ({count_o, overflow_o, drop_cnt_o} !== {3'd4, 1'b0, 8'd0}) begin mismatched++; $display("[TB] FAIL we0_full: got count %0d ovf %b drop %0d expected 4 0 0", count_o, overflow_o, drop_cnt_o); end
  endtask

`ifdef GARUDA_RESULT_BYPASS_EN
  task automatic test_bypass();
    driveCycle(0, 0, 0, 1, 0, 0, 0, 0, 0);
    rst_i = 0; clear_i = 0; valid_i = 1; we_i = 1; res_ready_i = 1;
    result_i = 32'd56; rd_addr_i = 5'd6; hartid_i = 2'd1; id_i = 3'd2;
    #1;
    compared++; if ({res_valid_o, res_data_o, count_o} !== {1'b1, 32'd56, 3'd0}) begin mismatched++; $display("[TB] FAIL bypass_comb: got v%b d%0d count %0d expected v1 d56 0", res_valid_o, res_data_o, count_o); end
    @(posedge clk_i); #1;
    valid_i = 0; we_i = 0;
    #1;
    compared++; if ({count_o, res_valid_o} !== {3'd0, 1'b0}) begin mismatched++; $display("[TB] FAIL bypass_nostore: got count %0d valid %b expected 0 0", count_o, res_valid_o); end
  endtask
`else
  task automatic test_random();
    tbEntry_t expHead;
    bit       expValid;
    for (int n = 0; n < 2000; n++) begin
      expValid = (refQ.size() != 0);
      expHead  = expValid ? refQ[0] : '0;
      compared++;
      if ({res_valid_o, res_data_o, res_rd_addr_o, res_hartid_o, res_id_o, count_o, full_o, overflow_o, drop_cnt_o} !==
          {expValid, expHead.data, expHead.rd, expHead.hart, expHead.id, 3'(refQ.size()), refQ.size() == DEPTH, refOvf, 8'(refDrop)}) begin
        mismatched++;
        $display("[TB] FAIL random[%0d]: got v%b d%h cnt%0d ovf%b drop%0d expected v%b d%h cnt%0d ovf%b drop%0d",
                 n, res_valid_o, res_data_o, count_o, overflow_o, drop_cnt_o,
                 expValid, expHead.data, refQ.size(), refOvf, refDrop);
      end
      driveCycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8,
                 $urandom_range(0, 31) == 0, $urandom_range(0, 1) == 1, $urandom,
                 5'($urandom), 2'($urandom), 3'($urandom));
    end
  endtask
`endif

  initial begin
    rst_i = 1; valid_i = 0; we_i = 0; clear_i = 0; res_ready_i = 0;
    result_i = '0; rd_addr_i = '0; hartid_i = '0; id_i = '0;
    refOvf = 0; refDrop = 0;
    test_reset();
    test_single();
    test_fill_drain();
    test_overflow();
    test_push_pop_full();
    test_clear();
    test_write_disable();
`ifdef GARUDA_RESULT_BYPASS_EN
    test_bypass();
`else
    test_random();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/garuda_result_buffer.md
GARUDA_RESULT_BUFFER -- requirements
Module: garuda_result_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32, result data width.
REQ-002 SHALL have parameter DEPTH, default 4, entry count; power of two, >= 2.
REQ-003 SHALL have parameter HARTID_W, default 2, hart ID width.
REQ-004 SHALL have parameter ID_W, default 3, transaction ID width.
REQ-005 SHALL have the following ports, listed as name, direction, width, meaning:
- clk_i  in  1  single clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  MAC result valid.
- we_i  in  1  MAC result writes register.
- result_i  in  XLEN  MAC result.
- rd_addr_i  in  5  destination register.
- hartid_i  in  HARTID_W  hart ID.
- id_i  in  ID_W  transaction ID.
- clear_i  in  1  synchronous flush.
- res_valid_o  out  1  head entry valid to core.
- res_ready_i  in  1  core accepts head.
- res_data_o  out  XLEN  head result.
- res_rd_addr_o  out  5  head destination.
- res_hartid_o  out  HARTID_W  head hart ID.
- res_id_o  out  ID_W  head transaction ID.
- full_o  out  1  count == DEPTH; issue logic stalls MAC issue.
- count_o  out  $clog2(DEPTH+1)  occupied entries.
- overflow_o  out  1  sticky: a result was dropped.
- drop_cnt_o  out  8  dropped results, saturating.

Function
REQ-006 SHALL push an entry when valid_i && we_i && !clear_i; valid_i with we_i=0 SHALL be ignored and not counted as a drop.
REQ-007 SHALL pop the head when res_valid_o && res_ready_i && !clear_i.
REQ-008 SHALL deliver entries in strict FIFO order; read/write pointers SHALL wrap modulo DEPTH.
REQ-009 SHALL drive res_valid_o = (count != 0), with the res_* fields equal to the head entry and held stable while res_valid_o && !res_ready_i.
REQ-010 SHALL give 1-cycle latency: a push at edge N makes the entry visible at the head after edge N when the buffer was empty.
REQ-011 SHALL accept a push when full if a pop occurs in the same cycle; count SHALL be unchanged and no drop recorded.
REQ-012 SHALL, on a push while full without a pop: discard the entry, set overflow_o, and increment drop_cnt_o, saturating at 255.
REQ-013 SHALL keep count unchanged on simultaneous push and pop at any occupancy 1..DEPTH.
REQ-014 SHALL, on clear_i: set count=0, reset both pointers, and clear overflow_o and drop_cnt_o; clear_i wins over a same-cycle push/pop, and the discarded push SHALL NOT count as a drop.
REQ-015 SHALL drive full_o and count_o from registered state only.

Reset
REQ-016 SHALL, when rst_i is high at a clock edge: count_o=0, pointers=0, res_valid_o=0, full_o=0, overflow_o=0, drop_cnt_o=0, res_data_o=0, res_rd_addr_o=0, res_hartid_o=0, res_id_o=0.
REQ-017 SHALL give rst_i priority over clear_i, push and pop; reset mid-stream SHALL discard all entries.

Configuration
REQ-018 SHALL, with macro GARUDA_RESULT_BYPASS_EN defined and count==0: drive res_valid_o = valid_i && we_i combinationally with res_* = the input fields; if res_ready_i is high, the entry SHALL NOT be stored, otherwise it SHALL be stored.
REQ-019 SHALL, with GARUDA_RESULT_BYPASS_EN undefined: have no combinational input-to-output path, with latency per REQ-010.

Verification
REQ-020 SHALL cover: reset, then push result=25 rd=5 id=1 with res_ready_i=1 -> res_valid_o high 1 cycle later with data 25, rd 5, id 1; count returns to 0.
REQ-021 SHALL cover: res_ready_i=0, push 4 results (10, 20, 30, 40) -> full_o=1 and count_o=4; then ready=1 -> outputs 10, 20, 30, 40 in order.
REQ-022 SHALL cover: full, fifth push -15 without pop -> overflow_o=1, drop_cnt_o=1, -15 never output; 300 further drops -> drop_cnt_o=255.
REQ-023 SHALL cover: full, simultaneous push 127 and pop -> count_o stays 4, overflow_o=0, 127 emerges after the remaining three entries.
REQ-024 SHALL cover: count=3 with clear_i and push in the same cycle -> count_o=0, res_valid_o=0, drop_cnt_o=0.
REQ-025 SHALL cover: valid_i=1, we_i=0 -> no push, count_o unchanged; with GARUDA_RESULT_BYPASS_EN, empty and ready, push 56 -> res_valid_o and data 56 in the same cycle, count_o stays 0.
